// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit with a MEM/WB result register.
// Drives a req/ack data port, lane-shifts stores, extends loads.
// Ports:
//   clk, rst            clock, async active-high reset
//   bubbleW, flushW     WB register hold / bubble
//   *_MEM               instruction fields from EX/MEM
//   mem_req/we/addr/wdata, mem_rdata/ack   data-memory port
//   mem_stall           hold request to the hazard unit
//   misalign_err        misaligned access in this cycle
//   *_WB                registered write-back outputs
module mem_access_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bubbleW,
  input  logic              flushW,
  input  logic [ADDR_W-1:0] alu_out_MEM,
  input  logic [31:0]       store_data_MEM,
  input  logic [4:0]        reg_dst_MEM,
  input  logic              wb_select_MEM,
  input  logic [2:0]        load_type_MEM,
  input  logic              reg_write_en_MEM,
  input  logic [3:0]        cache_write_en_MEM,
  output logic              mem_req,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              mem_stall,
  output logic              misalign_err,
  output logic              reg_write_en_WB,
  output logic [4:0]        reg_dst_WB,
  output logic [31:0]       result_WB
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t      state, state_nx;
  logic [31:0] rbuf;
  logic [1:0]  off;
  logic        is_ld, is_h, is_w;
  logic        access, misal, go;
  logic [31:0] sh, ld_data, result;

  assign off = alu_out_MEM[1:0];

  always_comb begin
    is_ld = 1'b0;
    is_h  = 1'b0;
    is_w  = 1'b0;
    unique case (load_type_MEM)
      3'd1, 3'd4: is_ld = 1'b1;
      3'd2, 3'd5: begin
        is_ld = 1'b1;
        is_h  = 1'b1;
      end
      3'd3: begin
        is_ld = 1'b1;
        is_w  = 1'b1;
      end
      default: ;
    endcase
  end

  assign access = is_ld | (|cache_write_en_MEM);
  assign misal =
    ((is_h | (cache_write_en_MEM == 4'b0011)) & off[0]) |
    ((is_w | (cache_write_en_MEM == 4'b1111)) & (|off));
  assign go = (state == IDLE) & access & ~misal;

  assign mem_stall    = go | (state == REQ);
  assign misalign_err = access & misal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (go) state_nx = REQ;
      REQ:     if (mem_ack) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Port outputs are launched from IDLE and held for the whole REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 4'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'b0;
      rbuf      <= 32'b0;
    end else if (go) begin
      mem_req   <= 1'b1;
      mem_we    <= cache_write_en_MEM << off;
      mem_addr  <= {alu_out_MEM[ADDR_W-1:2], 2'b00};
      mem_wdata <= store_data_MEM << {off, 3'b000};
    end else if (state == REQ && mem_ack) begin
      mem_req <= 1'b0;
      mem_we  <= 4'b0;
      rbuf    <= mem_rdata;
    end
  end

  assign sh = rbuf >> {off, 3'b000};

  always_comb begin
    ld_data = rbuf;
    unique case (load_type_MEM)
      3'd1:    ld_data = {{24{sh[7]}}, sh[7:0]};
      3'd2:    ld_data = {{16{sh[15]}}, sh[15:0]};
      3'd4:    ld_data = {24'b0, sh[7:0]};
      3'd5:    ld_data = {16'b0, sh[15:0]};
      default: ld_data = rbuf;
    endcase
  end

  assign result = wb_select_MEM ? ld_data : alu_out_MEM[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_en_WB <= 1'b0;
      reg_dst_WB      <= 5'b0;
      result_WB       <= 32'b0;
    end else if (bubbleW) begin
      reg_write_en_WB <= reg_write_en_WB;
    end else if (flushW | mem_stall) begin
      reg_write_en_WB <= 1'b0;
      reg_dst_WB      <= 5'b0;
      result_WB       <= 32'b0;
    end else begin
      reg_write_en_WB <= reg_write_en_MEM & ~misalign_err;
      reg_dst_WB      <= reg_dst_MEM;
      result_WB       <= result;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: scoreboard of expected WB results,
// a simple variable-latency memory responder inside the driver task.
module tb_mem_access_stage;

  logic        clk, rst, bubbleW, flushW;
  logic [31:0] alu_out_MEM, store_data_MEM;
  logic [4:0]  reg_dst_MEM;
  logic        wb_select_MEM;
  logic [2:0]  load_type_MEM;
  logic        reg_write_en_MEM;
  logic [3:0]  cache_write_en_MEM;
  logic        mem_req;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack, mem_stall, misalign_err;
  logic        reg_write_en_WB;
  logic [4:0]  reg_dst_WB;
  logic [31:0] result_WB;

  int n_cmp = 0;
  int n_err = 0;
  logic [37:0] sb[$];

  mem_access_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .bubbleW(bubbleW), .flushW(flushW),
    .alu_out_MEM(alu_out_MEM),
    .store_data_MEM(store_data_MEM),
    .reg_dst_MEM(reg_dst_MEM),
    .wb_select_MEM(wb_select_MEM),
    .load_type_MEM(load_type_MEM),
    .reg_write_en_MEM(reg_write_en_MEM),
    .cache_write_en_MEM(cache_write_en_MEM),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_stall(mem_stall),
    .misalign_err(misalign_err),
    .reg_write_en_WB(reg_write_en_WB),
    .reg_dst_WB(reg_dst_WB),
    .result_WB(result_WB)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic nop();
    alu_out_MEM        = 0;
    store_data_MEM     = 0;
    reg_dst_MEM        = 0;
    wb_select_MEM      = 0;
    load_type_MEM      = 0;
    reg_write_en_MEM   = 0;
    cache_write_en_MEM = 0;
  endtask

  // Drives one instruction, answers the memory port after ack_wait
  // extra REQ cycles, returns once the WB register has captured it.
  task automatic issue(
    input  logic [2:0]  lt,
    input  logic [3:0]  cwe,
    input  logic [31:0] addr,
    input  logic [31:0] sd,
    input  logic [4:0]  dst,
    input  logic        wbs,
    input  logic        rwe,
    input  logic [31:0] rdata,
    input  int          ack_wait,
    output int          st_n,
    output logic        err_seen,
    output logic        req_seen,
    output logic [3:0]  we0,
    output logic [31:0] ad0,
    output logic [31:0] wd0
  );
    int w;
    w = 0; st_n = 0; err_seen = 0; req_seen = 0;
    we0 = 0; ad0 = 0; wd0 = 0;
    @(negedge clk);
    load_type_MEM      = lt;
    cache_write_en_MEM = cwe;
    alu_out_MEM        = addr;
    store_data_MEM     = sd;
    reg_dst_MEM        = dst;
    wb_select_MEM      = wbs;
    reg_write_en_MEM   = rwe;
    mem_rdata          = rdata;
    mem_ack            = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (misalign_err) err_seen = 1;
      if (!mem_stall) break;
      st_n++;
      if (mem_req) begin
        if (!req_seen) begin
          req_seen = 1;
          we0 = mem_we; ad0 = mem_addr; wd0 = mem_wdata;
        end else begin
          n_cmp++;
          if ({mem_we, mem_addr, mem_wdata} !== {we0, ad0, wd0}) begin
            n_err++;
            $display("FAIL req_hold: got %h/%h/%h want %h/%h/%h",
                     mem_we, mem_addr, mem_wdata, we0, ad0, wd0);
          end
        end
        if (w == ack_wait) mem_ack = 1;
        else w++;
      end
      @(posedge clk);
      #1 mem_ack = 0;
      @(negedge clk);
    end
    if (mem_stall) begin
      n_cmp++; n_err++;
      $display("FAIL stall_timeout: stall still %b want 0", mem_stall);
    end
    @(posedge clk);
    #1 nop();
  endtask

  task automatic check_wb(input string nm);
    logic [37:0] e;
    e = sb.pop_front();
    n_cmp++;
    if ({reg_write_en_WB, reg_dst_WB, result_WB} !== e) begin
      n_err++;
      $display("FAIL %s: got we=%b dst=%0d res=%h want we=%b dst=%0d res=%h",
               nm, reg_write_en_WB, reg_dst_WB, result_WB,
               e[37], e[36:32], e[31:0]);
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== 69'b0) begin
      n_err++;
      $display("FAIL reset_port: got %b/%h/%h/%h want 0",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    n_cmp++;
    if ({mem_stall, misalign_err} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_flags: got %b%b want 00", mem_stall, misalign_err);
    end
    sb.push_back({1'b0, 5'd0, 32'h0});
    check_wb("reset_wb");
  endtask

  task automatic test_lw();
    int s; logic e, r; logic [3:0] we; logic [31:0] a, d;
    sb.push_back({1'b1, 5'd3, 32'hDEADBEEF});
    issue(3'd3, 4'b0, 32'h100, 0, 5'd3, 1, 1, 32'hDEADBEEF, 0, s, e, r, we, a, d);
    n_cmp++;
    if (s !== 2) begin
      n_err++;
      $display("FAIL lw_stall: got %0d cycles want 2", s);
    end
    n_cmp++;
    if ({we, a} !== {4'b0, 32'h100}) begin
      n_err++;
      $display("FAIL lw_port: got we=%b addr=%h want 0000/100", we, a);
    end
    check_wb("lw_wb");
  endtask

  task automatic test_load_ext();
    int s; logic e, r; logic [3:0] we; logic [31:0] a, d;
    logic [2:0]  lt[4]  = '{3'd1, 3'd4, 3'd5, 3'd2};
    logic [31:0] ad[4]  = '{32'h103, 32'h103, 32'h102, 32'h102};
    logic [31:0] ex[4]  = '{32'hFFFFFF80, 32'h00000080,
                            32'h00008012, 32'hFFFF8012};
    for (int i = 0; i < 4; i++) begin
      sb.push_back({1'b1, 5'(i + 4), ex[i]});
      issue(lt[i], 4'b0, ad[i], 0, 5'(i + 4), 1, 1, 32'h80123456, i,
            s, e, r, we, a, d);
      check_wb($sformatf("load_ext%0d", i));
    end
  endtask

  task automatic test_store();
    int s; logic e, r; logic [3:0] we; logic [31:0] a, d;
    sb.push_back({1'b0, 5'd0, 32'h206});
    issue(3'd0, 4'b0011, 32'h206, 32'h0000ABCD, 0, 0, 0, 0, 3,
          s, e, r, we, a, d);
    n_cmp++;
    if ({we, a, d} !== {4'b1100, 32'h204, 32'hABCD0000}) begin
      n_err++;
      $display("FAIL sh_port: got %b/%h/%h want 1100/204/abcd0000",
               we, a, d);
    end
    n_cmp++;
    if (s !== 5) begin
      n_err++;
      $display("FAIL sh_stall: got %0d cycles want 5", s);
    end
    check_wb("sh_wb");
    sb.push_back({1'b0, 5'd0, 32'h303});
    issue(3'd0, 4'b0001, 32'h303, 32'h000000A5, 0, 0, 0, 0, 1,
          s, e, r, we, a, d);
    n_cmp++;
    if ({we, a, d} !== {4'b1000, 32'h300, 32'hA5000000}) begin
      n_err++;
      $display("FAIL sb_port: got %b/%h/%h want 1000/300/a5000000",
               we, a, d);
    end
    check_wb("sb_wb");
  endtask

  task automatic test_misalign();
    int s; logic e, r; logic [3:0] we; logic [31:0] a, d;
    sb.push_back({1'b0, 5'd9, 32'h0});
    issue(3'd3, 4'b0, 32'h102, 0, 5'd9, 1, 1, 32'h12345678, 0,
          s, e, r, we, a, d);
    n_cmp++;
    if ({r, e, s[7:0]} !== {1'b0, 1'b1, 8'd0}) begin
      n_err++;
      $display("FAIL mis_flags: got req=%b err=%b stall=%0d want 0/1/0",
               r, e, s);
    end
    n_cmp++;
    if ({reg_write_en_WB, reg_dst_WB} !== {1'b0, 5'd9}) begin
      n_err++;
      $display("FAIL mis_wb: got we=%b dst=%0d want 0/9",
               reg_write_en_WB, reg_dst_WB);
    end
    void'(sb.pop_front());
    #1;
    n_cmp++;
    if ({misalign_err, mem_req} !== 2'b00) begin
      n_err++;
      $display("FAIL mis_clear: got err=%b req=%b want 00",
               misalign_err, mem_req);
    end
  endtask

  task automatic test_alu_flush_bubble();
    int s; logic e, r; logic [3:0] we; logic [31:0] a, d;
    sb.push_back({1'b1, 5'd7, 32'h55});
    issue(3'd0, 4'b0, 32'h55, 0, 5'd7, 0, 1, 0, 0, s, e, r, we, a, d);
    n_cmp++;
    if (s !== 0) begin
      n_err++;
      $display("FAIL alu_stall: got %0d cycles want 0", s);
    end
    check_wb("alu_wb");
    flushW = 1;
    sb.push_back({1'b0, 5'd0, 32'h0});
    issue(3'd0, 4'b0, 32'h55, 0, 5'd7, 0, 1, 0, 0, s, e, r, we, a, d);
    check_wb("flush_wb");
    flushW = 0;
    sb.push_back({1'b1, 5'd9, 32'h66});
    issue(3'd0, 4'b0, 32'h66, 0, 5'd9, 0, 1, 0, 0, s, e, r, we, a, d);
    check_wb("alu2_wb");
    bubbleW = 1;
    sb.push_back({1'b1, 5'd9, 32'h66});
    issue(3'd0, 4'b0, 32'h77, 0, 5'd11, 0, 1, 0, 0, s, e, r, we, a, d);
    check_wb("bubble_wb");
    bubbleW = 0;
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk);
    load_type_MEM = 3'd3; alu_out_MEM = 32'h300;
    wb_select_MEM = 1; reg_write_en_MEM = 1; reg_dst_MEM = 5'd2;
    @(negedge clk);
    #1;
    n_cmp++;
    if (mem_req !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre_req: got %b want 1", mem_req);
    end
    rst = 1;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL rst_async_req: got %b want 0", mem_req);
    end
    nop();
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_ack = 0;
    #1;
    n_cmp++;
    if ({mem_req, mem_stall, mem_we} !== 6'b0) begin
      n_err++;
      $display("FAIL stray_ack: got req=%b stall=%b we=%b want 0",
               mem_req, mem_stall, mem_we);
    end
    sb.push_back({1'b0, 5'd0, 32'h0});
    check_wb("stray_ack_wb");
  endtask

  initial begin
    rst = 1; bubbleW = 0; flushW = 0;
    mem_ack = 0; mem_rdata = 0;
    nop();
    repeat (2) @(negedge clk);
    test_reset();
    rst = 0;
    test_lw();
    test_load_ext();
    test_store();
    test_misalign();
    test_alu_flush_bubble();
    test_reset_mid_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM-stage data-memory access unit with an integrated MEM/WB result register. It sits directly downstream of the EX/MEM control segment register and consumes its wb_select, load_type, reg_write_en and cache_write_en outputs together with the EX/MEM address and store data. It drives a variable-latency req/ack data-memory port, shifts stores into byte lanes, and sign- or zero-extends loads. It stalls the pipeline while an access is outstanding and registers the write-back result for the WB stage.

## Interface
- ADDR_W, 32, byte-address width; data width is fixed at 32.
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- bubbleW  in  1  hold the WB register (no update).
- flushW  in  1  load a bubble into the WB register.
- alu_out_MEM  in  ADDR_W  ALU result; used as the memory byte address.
- store_data_MEM  in  32  unshifted store data (rs2).
- reg_dst_MEM  in  5  destination register.
- wb_select_MEM  in  1  write-back source: 1 = memory, 0 = ALU.
- load_type_MEM  in  3  load type: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU; 6 and 7 are treated as none.
- reg_write_en_MEM  in  1  register write enable.
- cache_write_en_MEM  in  4  unshifted byte mask: 0000 none, 0001 SB, 0011 SH, 1111 SW.
- mem_req  out  1  request valid.
- mem_we  out  4  byte write enables; 0000 means a read.
- mem_addr  out  ADDR_W  word-aligned address ({alu_out[ADDR_W-1:2],2'b00}).
- mem_wdata  out  32  lane-shifted store data.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion strobe.
- mem_stall  out  1  to the hazard unit; the hazard unit must hold EX/MEM and earlier stages while this is high.
- misalign_err  out  1  misaligned-access flag.
- reg_write_en_WB  out  1  registered write enable.
- reg_dst_WB  out  5  registered destination register.
- result_WB  out  32  registered write-back value.

## Operation
- access = (load_type_MEM in 1..5) or (cache_write_en_MEM != 0).
- Misaligned conditions:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0] != 0.
  - On a misaligned access: no memory request is issued, misalign_err is high in that cycle, mem_stall stays 0, and the instruction enters WB with reg_write_en forced to 0.
- FSM states:
  - IDLE
    - An aligned access raises mem_stall and moves to REQ.
    - Otherwise the FSM stays in IDLE.
  - REQ
    - mem_req=1; mem_addr, mem_we and mem_wdata are held stable.
    - mem_stall=1.
    - On mem_ack: capture mem_rdata into rbuf and move to DONE.
  - DONE
    - mem_stall=0; the instruction retires into the WB register.
    - Unconditionally returns to IDLE.
- Store lanes:
  - mem_we = cache_write_en_MEM << addr[1:0].
  - mem_wdata = store_data_MEM << (8*addr[1:0]).
  - Loads drive mem_we = 0000.
- Load extraction:
  - sh = rbuf >> (8*addr[1:0]).
  - LB: sign-extend sh[7:0].
  - LBU: zero-extend sh[7:0].
  - LH: sign-extend sh[15:0].
  - LHU: zero-extend sh[15:0].
  - LW: rbuf.
- WB mux: result = wb_select_MEM ? load_data : alu_out_MEM.
- WB register update, evaluated each posedge:
  - bubbleW=1: hold all WB outputs.
  - Else, flushW=1 or mem_stall=1: load zeros (bubble).
  - Else: capture reg_write_en (masked by misalignment), reg_dst and result.
- mem_ack while not in REQ is ignored.

## Timing
- Reset, asynchronous: state=IDLE; rbuf=0; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; reg_write_en_WB=0, reg_dst_WB=0, result_WB=0. mem_stall and misalign_err are 0 whenever inputs show no access.
- Reset mid-REQ aborts the access and deasserts mem_req immediately; a late mem_ack is then ignored.
- Minimum access sequence, with ack arriving in the first REQ cycle:
  - Cycle 0 (IDLE): stall.
  - Cycle 1 (REQ): ack.
  - Cycle 2 (DONE): no stall; the WB register is updated at the end of cycle 2.
  - mem_stall is therefore high for exactly 2 + (ack wait) cycles.
- Non-memory instructions add zero latency: captured into WB on the next edge.
- Instruction inputs must stay stable while mem_stall=1; the upstream hold guarantees this.
- bubbleW asserted in DONE keeps the FSM returning to IDLE. The hazard unit must not assert bubbleW while this block is in DONE.

## Test plan
- LW addr 0x100, mem_rdata=0xDEADBEEF, ack 1st REQ cycle -> mem_stall high 2 cycles; result_WB=0xDEADBEEF, reg_write_en_WB=1.
- LB addr 0x103, rdata=0x80123456 -> result_WB=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU addr 0x102 -> 0x00008012.
- SH addr 0x206, store_data=0x0000ABCD, cache_write_en=0011 -> mem_we=1100, mem_wdata=0xABCD0000, mem_addr=0x204. Ack delayed 3 cycles -> mem_req and its outputs held stable; mem_stall high for 5 cycles.
- LW addr 0x102 -> mem_req never asserted; misalign_err=1 for one cycle; no stall; reg_write_en_WB=0.
- Reset asserted mid-REQ -> mem_req drops without a clock edge. A subsequent stray mem_ack -> no state change; WB outputs remain 0.
- ADD result 0x55 with flushW=1 -> reg_write_en_WB=0, result_WB=0. With bubbleW=1 -> previous WB values are held.
